// File: rtl/exec_pkg.sv
// exec_pkg: shared constants and types for the execution-unit controller.
// Optional build macro used by the controller: MUL_EARLY_EXIT_EN.
package exec_pkg;

   // Default datapath width.
   localparam int EXEC_XLEN = 32;

   // alu_control encodings produced by the ALU decoder.
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_MUL = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;

   // Controller states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DONE = 2'd2
   } exec_state_t;

endpackage

// File: rtl/alu_core.sv
// alu_core: purely combinational single-cycle operations.
// The multiply code and the unused codes 110/111 produce 0 here; the
// multiply itself is iterated by the controller.
module alu_core
   import exec_pkg::*;
#(
   parameter int XLEN = EXEC_XLEN
) (
   input  logic [2:0]      alu_control,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic [XLEN-1:0] y
);

   // Select the operation result; all arithmetic wraps modulo 2^XLEN.
   always_comb begin
      y = '0;
      case (alu_control)
         ALU_ADD: y = a + b;
         ALU_SUB: y = a - b;
         ALU_AND: y = a & b;
         ALU_OR:  y = a | b;
         ALU_SLT: y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/exec_unit_ctrl.sv
// exec_unit_ctrl: valid/ready execution unit with single-cycle ALU ops and
// an iterative shift-add multiplier.
// Build macro MUL_EARLY_EXIT_EN: when defined, a multiply finishes as soon
// as the multiplier register has been shifted down to 0 (src_b==0 completes
// directly from IDLE). Results are identical either way; only latency differs.
//
// Handshake: an input op transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready. While a
// result waits (out_valid && !out_ready) result/zero are frozen.
module exec_unit_ctrl
   import exec_pkg::*;
#(
   parameter int XLEN = EXEC_XLEN
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      alu_control,
   input  logic [XLEN-1:0] src_a,
   input  logic [XLEN-1:0] src_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            busy,
   output logic            stall
);

   exec_state_t     r_state;
   logic [XLEN-1:0] r_result;
   logic [XLEN-1:0] r_mcand;
   logic [XLEN-1:0] r_mplier;
   logic [XLEN-1:0] r_acc;
   logic [5:0]      r_cnt;

   logic [XLEN-1:0] w_alu_y;
   logic [XLEN-1:0] w_acc_next;
   logic [XLEN-1:0] w_mplier_next;
   logic            w_in_ready;
   logic            w_accept;
   logic            w_start_mul;
   logic            w_mul_last;

   alu_core #(.XLEN(XLEN)) u_alu_core (
      .alu_control (alu_control),
      .a           (src_a),
      .b           (src_b),
      .y           (w_alu_y)
   );

   // Handshake and status decode; in_ready is held low while rst is high.
   always_comb begin
      w_in_ready = !rst && ((r_state == ST_IDLE) ||
                            ((r_state == ST_DONE) && out_ready));
      w_accept   = in_valid && w_in_ready;
   end

   assign in_ready  = w_in_ready;
   assign out_valid = (r_state == ST_DONE);
   assign busy      = (r_state != ST_IDLE);
   assign stall     = in_valid && !w_in_ready;
   assign result    = r_result;
   assign zero      = (r_result == '0);

   // One shift-add iteration and the decision whether it is the last one.
   always_comb begin
      w_acc_next    = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
      w_mplier_next = r_mplier >> 1;
`ifdef MUL_EARLY_EXIT_EN
      w_mul_last  = (w_mplier_next == '0) || (r_cnt == 6'(XLEN-1));
      // A zero multiplier needs no iterations: the ALU path yields 0 for the mul code.
      w_start_mul = (alu_control == ALU_MUL) && (src_b != '0);
`else
      w_mul_last  = (r_cnt == 6'(XLEN-1));
      w_start_mul = (alu_control == ALU_MUL);
`endif
   end

   // Controller state, result register and multiplier datapath.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_result <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (w_accept) begin
                  if (w_start_mul) begin
                     r_mcand  <= src_a;
                     r_mplier <= src_b;
                     r_acc    <= '0;
                     r_cnt    <= '0;
                     r_state  <= ST_MUL;
                  end else begin
                     r_result <= w_alu_y;
                     r_state  <= ST_DONE;
                  end
               end else if ((r_state == ST_DONE) && out_ready) begin
                  r_state <= ST_IDLE;
               end
            end
            ST_MUL: begin
               r_acc    <= w_acc_next;
               r_mcand  <= r_mcand << 1;
               r_mplier <= w_mplier_next;
               r_cnt    <= r_cnt + 6'd1;
               if (w_mul_last) begin
                  r_result <= w_acc_next;
                  r_state  <= ST_DONE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_exec_unit_ctrl.sv
// tb_exec_unit_ctrl: directed self-checking bench for exec_unit_ctrl.
// Expected multiply latencies follow MUL_EARLY_EXIT_EN when it is defined.
module tb_exec_unit_ctrl;

   localparam int XLEN = 32;

   logic            clk;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [2:0]      alu_control;
   logic [XLEN-1:0] src_a;
   logic [XLEN-1:0] src_b;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;
   logic            zero;
   logic            busy;
   logic            stall;

   int checks = 0;
   int errors = 0;

   exec_unit_ctrl #(.XLEN(XLEN)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .alu_control (alu_control),
      .src_a       (src_a),
      .src_b       (src_b),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .zero        (zero),
      .busy        (busy),
      .stall       (stall)
   );

   // Clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Driver: offer one op with out_ready=1, return cycles from accept to
   // out_valid (1 = next cycle), plus result and zero seen at that point.
   task automatic do_op(input logic [2:0] op, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, output int lat,
                        output logic [XLEN-1:0] res, output logic z);
      int guard;
      @(negedge clk);
      alu_control = op;
      src_a       = a;
      src_b       = b;
      in_valid    = 1'b1;
      out_ready   = 1'b1;
      guard = 0;
      while (!in_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      res = result;
      z   = zero;
   endtask

   task automatic test_reset;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      alu_control = 3'b000;
      src_a = '0;
      src_b = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (result !== '0) begin errors++; $display("FAIL reset_result got %h exp 0", result); end
      checks++; if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero got %b exp 1", zero); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
      rst = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b exp 1", in_ready); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL post_reset_stall got %b exp 0", stall); end
   endtask

   task automatic test_alu_ops;
      int lat;
      logic [XLEN-1:0] res;
      logic z;
      do_op(3'b000, 32'd5, 32'd7, lat, res, z);
      checks++; if (lat !== 1) begin errors++; $display("FAIL add_latency got %0d exp 1", lat); end
      checks++; if (res !== 32'd12) begin errors++; $display("FAIL add_result got %h exp 0000000c", res); end
      checks++; if (z !== 1'b0) begin errors++; $display("FAIL add_zero got %b exp 0", z); end
      // No new op: DONE hands off and returns to IDLE.
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drop_out_valid got %b exp 0", out_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL add_idle_busy got %b exp 0", busy); end

      do_op(3'b101, 32'hFFFF_FFFF, 32'd1, lat, res, z);
      checks++; if (res !== 32'd1) begin errors++; $display("FAIL slt_neg_result got %h exp 00000001", res); end
      do_op(3'b101, 32'd1, 32'hFFFF_FFFF, lat, res, z);
      checks++; if (res !== 32'd0) begin errors++; $display("FAIL slt_pos_result got %h exp 00000000", res); end
      do_op(3'b001, 32'd9, 32'd9, lat, res, z);
      checks++; if (res !== 32'd0) begin errors++; $display("FAIL sub_result got %h exp 00000000", res); end
      checks++; if (z !== 1'b1) begin errors++; $display("FAIL sub_zero got %b exp 1", z); end
      do_op(3'b010, 32'hF0F0_1234, 32'h0FF0_FFFF, lat, res, z);
      checks++; if (res !== 32'h00F0_1234) begin errors++; $display("FAIL and_result got %h exp 00f01234", res); end
      do_op(3'b011, 32'hF000_0000, 32'h0000_000F, lat, res, z);
      checks++; if (res !== 32'hF000_000F) begin errors++; $display("FAIL or_result got %h exp f000000f", res); end
      do_op(3'b000, 32'hFFFF_FFFF, 32'd2, lat, res, z);
      checks++; if (res !== 32'd1) begin errors++; $display("FAIL add_wrap_result got %h exp 00000001", res); end
      do_op(3'b110, 32'h1234_5678, 32'h1, lat, res, z);
      checks++; if (res !== 32'd0) begin errors++; $display("FAIL code110_result got %h exp 00000000", res); end
      checks++; if (lat !== 1) begin errors++; $display("FAIL code110_latency got %0d exp 1", lat); end
      do_op(3'b111, 32'h5, 32'h5, lat, res, z);
      checks++; if (z !== 1'b1) begin errors++; $display("FAIL code111_zero got %b exp 1", z); end
   endtask

   task automatic test_mul;
      int lat;
      logic [XLEN-1:0] res;
      logic z;
      int exp_lat_67;
      int exp_lat_big;
      int exp_lat_zero;
`ifdef MUL_EARLY_EXIT_EN
      exp_lat_67   = 4;
      exp_lat_big  = 18;
      exp_lat_zero = 1;
`else
      exp_lat_67   = 33;
      exp_lat_big  = 33;
      exp_lat_zero = 33;
`endif
      do_op(3'b100, 32'd6, 32'd7, lat, res, z);
      checks++; if (res !== 32'd42) begin errors++; $display("FAIL mul_6x7_result got %h exp 0000002a", res); end
      checks++; if (lat !== exp_lat_67) begin errors++; $display("FAIL mul_6x7_latency got %0d exp %0d", lat, exp_lat_67); end
      do_op(3'b100, 32'h0001_0000, 32'h0001_0000, lat, res, z);
      checks++; if (res !== 32'd0) begin errors++; $display("FAIL mul_wrap_result got %h exp 00000000", res); end
      checks++; if (z !== 1'b1) begin errors++; $display("FAIL mul_wrap_zero got %b exp 1", z); end
      checks++; if (lat !== exp_lat_big) begin errors++; $display("FAIL mul_wrap_latency got %0d exp %0d", lat, exp_lat_big); end
      do_op(3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, res, z);
      checks++; if (res !== 32'd1) begin errors++; $display("FAIL mul_max_result got %h exp 00000001", res); end
      checks++; if (lat !== 33) begin errors++; $display("FAIL mul_max_latency got %0d exp 33", lat); end
      do_op(3'b100, 32'd123, 32'd0, lat, res, z);
      checks++; if (res !== 32'd0) begin errors++; $display("FAIL mul_by0_result got %h exp 00000000", res); end
      checks++; if (lat !== exp_lat_zero) begin errors++; $display("FAIL mul_by0_latency got %0d exp %0d", lat, exp_lat_zero); end
   endtask

   task automatic test_back_to_back;
      @(negedge clk);
      alu_control = 3'b000;
      src_a       = 32'd3;
      src_b       = 32'd4;
      in_valid    = 1'b1;
      out_ready   = 1'b0;
      @(posedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i == 0) begin
            src_a = 32'd10;
            src_b = 32'd20;
         end
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid cyc %0d got %b exp 1", i, out_valid); end
         checks++; if (result !== 32'd7) begin errors++; $display("FAIL bp_result_hold cyc %0d got %h exp 00000007", i, result); end
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc %0d got %b exp 0", i, in_ready); end
         checks++; if (stall !== 1'b1) begin errors++; $display("FAIL bp_stall cyc %0d got %b exp 1", i, stall); end
      end
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got %b exp 1", in_ready); end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_out_valid got %b exp 1", out_valid); end
      checks++; if (result !== 32'd30) begin errors++; $display("FAIL b2b_result got %h exp 0000001e", result); end
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy got %b exp 0", busy); end
   endtask

   task automatic test_reset_mid_mul;
      int lat;
      logic [XLEN-1:0] res;
      logic z;
      int spurious;
      do_op(3'b000, 32'd5, 32'd5, lat, res, z);
      // Multiplier with only the top bit set keeps the multiply running 32 cycles.
      @(negedge clk);
      alu_control = 3'b100;
      src_a       = 32'd3;
      src_b       = 32'h8000_0000;
      in_valid    = 1'b1;
      out_ready   = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k < 10) begin
            src_a = 32'(k);
            alu_control = 3'b000;
            checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mul_stall cyc %0d got %b exp 1", k, stall); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mul_busy cyc %0d got %b exp 1", k, busy); end
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mul_out_valid cyc %0d got %b exp 0", k, out_valid); end
         end else begin
            rst      = 1'b1;
            in_valid = 1'b0;
         end
      end
      @(posedge clk);
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mul_busy got %b exp 0", busy); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mul_out_valid got %b exp 0", out_valid); end
      checks++; if (result !== '0) begin errors++; $display("FAIL rst_mul_result got %h exp 00000000", result); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_mul_in_ready got %b exp 0", in_ready); end
      rst = 1'b0;
      spurious = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (out_valid) spurious++;
      end
      checks++; if (spurious !== 0) begin errors++; $display("FAIL rst_mul_ghost_result got %0d exp 0", spurious); end
      do_op(3'b000, 32'd1, 32'd1, lat, res, z);
      checks++; if (res !== 32'd2) begin errors++; $display("FAIL post_rst_add_result got %h exp 00000002", res); end
      checks++; if (lat !== 1) begin errors++; $display("FAIL post_rst_add_latency got %0d exp 1", lat); end
   endtask

   // Test sequence and final report.
   initial begin
      test_reset();
      test_alu_ops();
      test_mul();
      test_back_to_back();
      test_reset_mid_mul();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout got running exp finished");
      $fatal(1, "simulation time limit reached");
   end

endmodule
